rob_nway: RTL and testbench
===========================

# rob_nway

Parametrised N-way reorder buffer for the out-of-order backend. It accepts up to `DISPATCH_WIDTH` renamed instructions per cycle from dispatch and marks entries complete from `CDB_WIDTH` writeback buses. It retires up to `COMMIT_WIDTH` completed entries per cycle, in program order, to the retirement RAT (RRF). Optionally, it flushes the whole window when a flush-tagged entry commits.

## Interface

Parameters:
- `ROB_DEPTH`, 32: number of entries; any value ≥ `DISPATCH_WIDTH`, not required to be a power of two.
- `DISPATCH_WIDTH`, 2: dispatch lanes.
- `COMMIT_WIDTH`, 2: commit lanes.
- `CDB_WIDTH`, 2: writeback buses.
- `PRF_IDX`, 6 and `ARF_IDX`, 5: physical and architectural register index widths.
- `ROB_IDX`: derived, `$clog2(ROB_DEPTH)`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `disp_valid` in DISPATCH_WIDTH: per-lane dispatch request, any bit pattern.
- `disp_rd_arch` in DISPATCH_WIDTH×ARF_IDX: destination architectural register per lane.
- `disp_rd_phy` in DISPATCH_WIDTH×PRF_IDX: destination physical register per lane.
- `disp_ready` out 1: ROB can accept a full dispatch group this cycle.
- `disp_rob_id` out DISPATCH_WIDTH×ROB_IDX: entry allocated to each lane.
- `cdb_valid` in CDB_WIDTH: writeback strobe per bus.
- `cdb_rob_id` in CDB_WIDTH×ROB_IDX: completing entry per bus.
- `cdb_flush` in CDB_WIDTH: completing entry requests a flush; exists only with `ROB_FLUSH_EN`.
- `commit_ready` in 1: RRF accepts commits this cycle.
- `commit_valid` out COMMIT_WIDTH: per-lane retire, always a contiguous prefix starting at lane 0.
- `commit_rd_arch` out COMMIT_WIDTH×ARF_IDX: architectural register being retired per lane.
- `commit_rd_phy` out COMMIT_WIDTH×PRF_IDX: physical register being retired per lane.
- `flush_valid` out 1: registered flush pulse; exists only with `ROB_FLUSH_EN`.

## Operation

State:
- Registers: `head`, `tail` (ROB_IDX bits) and `count` (`$clog2(ROB_DEPTH+1)` bits).
- Per-entry state: `ready`, `flush`, `rd_arch`, `rd_phy`.
- Pointer arithmetic is modulo `ROB_DEPTH`. Wrap explicitly: `p+k ≥ ROB_DEPTH` maps to `p+k−ROB_DEPTH`.

Dispatch:
- `disp_ready = (ROB_DEPTH − count ≥ DISPATCH_WIDTH)`.
- The ready check does not account for same-cycle commits.
- Lane i is allocated `tail + popcount(disp_valid[i−1:0])`. `disp_rob_id[i]` is that slot, even when lane i is invalid.
- On `disp_valid[i] && disp_ready`, the slot is written with `ready=0`, `flush=0`, `rd_arch`, `rd_phy`.
- `tail` advances by popcount(accepted lanes).

Writeback:
- `cdb_valid[k]` sets `ready[cdb_rob_id[k]]`.
- With the macro defined, it also ORs `cdb_flush[k]` into `flush[cdb_rob_id[k]]`.
- Multiple buses may target distinct entries in the same cycle.
- A CDB write to a non-allocated slot is illegal and does not need to be detected.

Commit:
- Lane j is valid iff `commit_ready`, `j < count`, and `ready` is set for `head+0` through `head+j`.
- Commit is in-order. Lane j never asserts when a lower lane is deasserted.
- `head` advances and `count` decrements by the number of committed lanes. Committed slots have `ready` cleared.
- `count` next value is `count + dispatched − committed`.

Flush (with `ROB_FLUSH_EN`):
- When committing lane j has `flush` set, lanes above j are suppressed.
- At the next edge, all `ready` bits clear, `count←0`, and `head←tail←` the slot after lane j.
- All dispatches in that cycle are discarded.
- `flush_valid` pulses for exactly the following cycle.
- `disp_ready` is 0 in the flush-detect cycle and in the `flush_valid` cycle.

## Timing

- Reset state: `head=tail=count=0`, all `ready`/`flush`=0.
- Outputs during reset: `commit_valid=0`, `flush_valid=0`, `disp_ready=1`, `disp_rob_id[i]=i`.
- `disp_ready`, `disp_rob_id` and the commit outputs are combinational from registered state plus `disp_valid`/`commit_ready`. There is no combinational path from `cdb_*`.
- An entry completed on the CDB in cycle N is commit-eligible in cycle N+1. Dispatch in N → earliest commit in N+2.
- Full: `count==ROB_DEPTH` → `disp_ready=0`, and commit continues.
- Empty: `count==0` → all `commit_valid`=0.
- Wrap-around applies to dispatch groups and commit groups that straddle slot `ROB_DEPTH−1`.
- Reset asserted mid-operation immediately discards all entries and forces the reset output values.

## Configuration

- `ROB_FLUSH_EN` defined: `cdb_flush`, `flush_valid`, the per-entry `flush` bit and the flush behaviour above are present.
- Undefined: those ports and that state do not exist, and commit stops only on not-ready or `commit_ready=0`.

## Test plan

1. Reset, then dispatch `disp_valid=2'b11` → `disp_rob_id={1,0}`. CDB completes both in cycle 2 → in cycle 3, `commit_valid=2'b11` with matching `rd_arch`/`rd_phy`.
2. Out-of-order completion: entries 0–3 allocated, CDB completes 1, 2, 3 → no commit. Completing 0 → commits lanes 0,1 (entries 0,1), then lanes 0,1 (entries 2,3) next cycle.
3. `ROB_DEPTH=5`, `DISPATCH_WIDTH=2`: fill to `count=4` → `disp_ready=0`. Commit 1 → `disp_ready=1`. Next group gets IDs {0,4}, covering the wrap.
4. `disp_valid=2'b10` → lane 1 gets ID `tail`, and `tail` advances by 1.
5. `ROB_FLUSH_EN`: entries 0–3 all ready, and entry 1 has the flush tag → in the commit cycle only lanes 0,1 commit. Next cycle `flush_valid=1`, `count=0`, `head=tail=2`, and `disp_ready=0`.
6. Hold `commit_ready=0` with all entries ready → no commits and `count` unchanged. Assert `rst` mid-stream → `commit_valid=0` and `disp_rob_id[0]=0` immediately.

Source files
------------

// File: rtl/rob_nway_if.sv
// Dispatch, writeback and commit bundle for rob_nway. Flush signals exist only with ROB_FLUSH_EN.
interface rob_nway_if #(
  parameter int ROB_DEPTH      = 32,
  parameter int DISPATCH_WIDTH = 2,
  parameter int COMMIT_WIDTH   = 2,
  parameter int CDB_WIDTH      = 2,
  parameter int PRF_IDX        = 6,
  parameter int ARF_IDX        = 5
);
  localparam int ROB_IDX = $clog2(ROB_DEPTH);

  logic [DISPATCH_WIDTH-1:0]              disp_valid;
  logic [DISPATCH_WIDTH-1:0][ARF_IDX-1:0] disp_rd_arch;
  logic [DISPATCH_WIDTH-1:0][PRF_IDX-1:0] disp_rd_phy;
  logic                                   disp_ready;
  logic [DISPATCH_WIDTH-1:0][ROB_IDX-1:0] disp_rob_id;

  logic [CDB_WIDTH-1:0]                   cdb_valid;
  logic [CDB_WIDTH-1:0][ROB_IDX-1:0]      cdb_rob_id;
`ifdef ROB_FLUSH_EN
  logic [CDB_WIDTH-1:0]                   cdb_flush;
  logic                                   flush_valid;
`endif

  logic                                   commit_ready;
  logic [COMMIT_WIDTH-1:0]                commit_valid;
  logic [COMMIT_WIDTH-1:0][ARF_IDX-1:0]   commit_rd_arch;
  logic [COMMIT_WIDTH-1:0][PRF_IDX-1:0]   commit_rd_phy;

  modport master (
    output disp_valid, disp_rd_arch, disp_rd_phy, cdb_valid, cdb_rob_id, commit_ready,
`ifdef ROB_FLUSH_EN
    output cdb_flush,
    input  flush_valid,
`endif
    input  disp_ready, disp_rob_id, commit_valid, commit_rd_arch, commit_rd_phy
  );

  modport slave (
    input  disp_valid, disp_rd_arch, disp_rd_phy, cdb_valid, cdb_rob_id, commit_ready,
`ifdef ROB_FLUSH_EN
    input  cdb_flush,
    output flush_valid,
`endif
    output disp_ready, disp_rob_id, commit_valid, commit_rd_arch, commit_rd_phy
  );
endinterface

// File: rtl/rob_nway.sv
// N-way in-order-retire reorder buffer; dispatch/commit outputs are combinational from state.
// Optional whole-window flush on commit of a flush-tagged entry: define ROB_FLUSH_EN.
module rob_nway #(
  parameter int ROB_DEPTH      = 32,
  parameter int DISPATCH_WIDTH = 2,
  parameter int COMMIT_WIDTH   = 2,
  parameter int CDB_WIDTH      = 2,
  parameter int PRF_IDX        = 6,
  parameter int ARF_IDX        = 5
) (
  input logic       clk,
  input logic       rst,
  rob_nway_if.slave bus
);
  localparam int ROB_IDX = $clog2(ROB_DEPTH);
  localparam int CNT_W   = $clog2(ROB_DEPTH + 1);
  typedef logic [ROB_IDX-1:0] idx_t;

  idx_t             head, tail, head_d, tail_d;
  logic [CNT_W-1:0] count, count_d;
  logic [ROB_DEPTH-1:0] rdy_q, rdy_d;
  logic [ARF_IDX-1:0]   arch_q [ROB_DEPTH];
  logic [PRF_IDX-1:0]   phy_q  [ROB_DEPTH];

  idx_t disp_slot [DISPATCH_WIDTH];
  idx_t com_slot  [COMMIT_WIDTH];
  logic [COMMIT_WIDTH-1:0] com_vld;
  logic disp_ok;
  logic alive;
  int   n_req, n_acc, n_com;

`ifdef ROB_FLUSH_EN
  logic [ROB_DEPTH-1:0] flg_q, flg_d;
  logic flush_hit, flush_valid_q;
  idx_t flush_slot;
`endif

  // Explicit modulo: operands never exceed two windows, so one subtract suffices.
  function automatic idx_t wrap_add(input idx_t p, input int k);
    logic [31:0] s;
    s = 32'(p) + 32'(k);
    if (s >= 32'(ROB_DEPTH)) s = s - 32'(ROB_DEPTH);
    return idx_t'(s);
  endfunction

  always_comb begin
    n_req = 0;
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      disp_slot[i]       = wrap_add(tail, n_req);
      bus.disp_rob_id[i] = disp_slot[i];
      if (bus.disp_valid[i]) n_req = n_req + 1;
    end
    disp_ok = (ROB_DEPTH - int'(count)) >= DISPATCH_WIDTH;
`ifdef ROB_FLUSH_EN
    disp_ok = disp_ok && !flush_hit && !flush_valid_q;
`endif
    n_acc = disp_ok ? n_req : 0;
  end

  assign bus.disp_ready = disp_ok;

  // Commit lanes form a prefix: the first non-eligible lane kills all higher lanes.
  always_comb begin
    alive   = bus.commit_ready;
    n_com   = 0;
    com_vld = '0;
`ifdef ROB_FLUSH_EN
    flush_hit  = 1'b0;
    flush_slot = head;
`endif
    for (int j = 0; j < COMMIT_WIDTH; j++) begin
      com_slot[j]           = wrap_add(head, j);
      bus.commit_rd_arch[j] = arch_q[com_slot[j]];
      bus.commit_rd_phy[j]  = phy_q[com_slot[j]];
      if (alive && (j < int'(count)) && rdy_q[com_slot[j]]) begin
        com_vld[j] = 1'b1;
        n_com      = j + 1;
`ifdef ROB_FLUSH_EN
        if (flg_q[com_slot[j]]) begin
          alive      = 1'b0;
          flush_hit  = 1'b1;
          flush_slot = wrap_add(head, j + 1);
        end
`endif
      end else begin
        alive = 1'b0;
      end
    end
  end

  assign bus.commit_valid = com_vld;

  always_comb begin
    rdy_d   = rdy_q;
    head_d  = wrap_add(head, n_com);
    tail_d  = wrap_add(tail, n_acc);
    count_d = CNT_W'(int'(count) + n_acc - n_com);
`ifdef ROB_FLUSH_EN
    flg_d = flg_q;
`endif
    for (int j = 0; j < COMMIT_WIDTH; j++) begin
      if (com_vld[j]) begin
        rdy_d[com_slot[j]] = 1'b0;
`ifdef ROB_FLUSH_EN
        flg_d[com_slot[j]] = 1'b0;
`endif
      end
    end
    for (int k = 0; k < CDB_WIDTH; k++) begin
      if (bus.cdb_valid[k]) begin
        rdy_d[bus.cdb_rob_id[k]] = 1'b1;
`ifdef ROB_FLUSH_EN
        flg_d[bus.cdb_rob_id[k]] = flg_d[bus.cdb_rob_id[k]] | bus.cdb_flush[k];
`endif
      end
    end
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      if (bus.disp_valid[i] && disp_ok) begin
        rdy_d[disp_slot[i]] = 1'b0;
`ifdef ROB_FLUSH_EN
        flg_d[disp_slot[i]] = 1'b0;
`endif
      end
    end
`ifdef ROB_FLUSH_EN
    if (flush_hit) begin
      rdy_d   = '0;
      flg_d   = '0;
      head_d  = flush_slot;
      tail_d  = flush_slot;
      count_d = '0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      rdy_q <= '0;
`ifdef ROB_FLUSH_EN
      flg_q         <= '0;
      flush_valid_q <= 1'b0;
`endif
    end else begin
      head  <= head_d;
      tail  <= tail_d;
      count <= count_d;
      rdy_q <= rdy_d;
`ifdef ROB_FLUSH_EN
      flg_q         <= flg_d;
      flush_valid_q <= flush_hit;
`endif
    end
  end

`ifdef ROB_FLUSH_EN
  assign bus.flush_valid = flush_valid_q;
`endif

  // Payload needs no reset: an entry is only read once its ready bit is set.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      if (bus.disp_valid[i] && disp_ok) begin
        arch_q[disp_slot[i]] <= bus.disp_rd_arch[i];
        phy_q[disp_slot[i]]  <= bus.disp_rd_phy[i];
      end
    end
  end
endmodule

// File: tb/tb_rob_nway.sv
module tb_rob_nway;
  localparam int DEPTH = 5;
  localparam int DW = 2;
  localparam int CW = 2;
  localparam int CB = 2;

  typedef struct packed {
    logic [4:0] arch;
    logic [5:0] phy;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  ent_t sb [$];

  always #5 clk = ~clk;

  rob_nway_if #(.ROB_DEPTH(DEPTH), .DISPATCH_WIDTH(DW), .COMMIT_WIDTH(CW),
                .CDB_WIDTH(CB), .PRF_IDX(6), .ARF_IDX(5)) bus ();

  rob_nway #(.ROB_DEPTH(DEPTH), .DISPATCH_WIDTH(DW), .COMMIT_WIDTH(CW),
             .CDB_WIDTH(CB), .PRF_IDX(6), .ARF_IDX(5)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  // Scoreboard: accepted dispatches are pushed, retirements popped in program order.
  always @(negedge clk) begin
    if (!rst) begin
      for (int j = 0; j < CW; j++) begin
        if (bus.commit_valid[j]) begin
          checks++;
          if (sb.size() == 0) begin
            failures++;
            $display("FAIL sb_commit lane%0d: unexpected retire arch=%0d phy=%0d, nothing outstanding",
                     j, bus.commit_rd_arch[j], bus.commit_rd_phy[j]);
          end else begin
            ent_t e;
            e = sb.pop_front();
            if (bus.commit_rd_arch[j] !== e.arch || bus.commit_rd_phy[j] !== e.phy) begin
              failures++;
              $display("FAIL sb_commit lane%0d: got arch=%0d phy=%0d want arch=%0d phy=%0d",
                       j, bus.commit_rd_arch[j], bus.commit_rd_phy[j], e.arch, e.phy);
            end
          end
        end
      end
      for (int i = 0; i < DW; i++)
        if (bus.disp_valid[i] && bus.disp_ready)
          sb.push_back('{arch: bus.disp_rd_arch[i], phy: bus.disp_rd_phy[i]});
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_disp(input logic [1:0] v);
    bus.disp_valid = v;
    for (int i = 0; i < DW; i++) begin
      bus.disp_rd_arch[i] = 5'($urandom);
      bus.disp_rd_phy[i]  = 6'($urandom);
    end
  endtask

  task automatic set_cdb(input logic [1:0] v, input int id0, input int id1, input logic [1:0] fl);
    bus.cdb_valid     = v;
    bus.cdb_rob_id[0] = 3'(id0);
    bus.cdb_rob_id[1] = 3'(id1);
`ifdef ROB_FLUSH_EN
    bus.cdb_flush = fl;
`else
    if (fl != 2'b00) $display("note: cdb flush tag ignored in this build");
`endif
  endtask

  task automatic test_reset;
    set_disp(2'b11);
    #1;
    checks++;
    if (bus.commit_valid !== 2'b00) begin failures++; $display("FAIL reset_commit: got %b want 00", bus.commit_valid); end
    checks++;
    if (bus.disp_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", bus.disp_ready); end
    checks++;
    if (bus.disp_rob_id[0] !== 3'd0 || bus.disp_rob_id[1] !== 3'd1) begin
      failures++; $display("FAIL reset_ids: got %0d/%0d want 0/1", bus.disp_rob_id[0], bus.disp_rob_id[1]);
    end
`ifdef ROB_FLUSH_EN
    checks++;
    if (bus.flush_valid !== 1'b0) begin failures++; $display("FAIL reset_flush: got %b want 0", bus.flush_valid); end
`endif
    tick;
    rst = 1'b0;
    set_disp(2'b00);
    tick;
  endtask

  task automatic test_basic;
    set_disp(2'b11);
    @(negedge clk);
    checks++;
    if (bus.disp_ready !== 1'b1 || bus.disp_rob_id[0] !== 3'd0 || bus.disp_rob_id[1] !== 3'd1) begin
      failures++; $display("FAIL basic_alloc: got rdy=%b ids=%0d/%0d want rdy=1 ids=0/1",
                           bus.disp_ready, bus.disp_rob_id[0], bus.disp_rob_id[1]);
    end
    tick; set_disp(2'b00); set_cdb(2'b11, 0, 1, 2'b00);
    @(negedge clk);
    checks++;
    if (bus.commit_valid !== 2'b00) begin failures++; $display("FAIL basic_early: got %b want 00", bus.commit_valid); end
    tick; set_cdb(2'b00, 0, 0, 2'b00);
    @(negedge clk);
    checks++;
    if (bus.commit_valid !== 2'b11) begin failures++; $display("FAIL basic_commit: got %b want 11", bus.commit_valid); end
    tick;
    @(negedge clk);
    checks++;
    if (bus.commit_valid !== 2'b00 || bus.disp_rob_id[0] !== 3'd2) begin
      failures++; $display("FAIL basic_after: got cv=%b tail=%0d want cv=00 tail=2", bus.commit_valid, bus.disp_rob_id[0]);
    end
    tick;
  endtask

  task automatic test_ooo;
    set_disp(2'b11);
    @(negedge clk);
    checks++;
    if (bus.disp_rob_id[0] !== 3'd2 || bus.disp_rob_id[1] !== 3'd3) begin
      failures++; $display("FAIL ooo_ids1: got %0d/%0d want 2/3", bus.disp_rob_id[0], bus.disp_rob_id[1]);
    end
    tick; set_disp(2'b11);
    @(negedge clk);
    checks++;
    if (bus.disp_ready !== 1'b1 || bus.disp_rob_id[0] !== 3'd4 || bus.disp_rob_id[1] !== 3'd0) begin
      failures++; $display("FAIL ooo_wrap_ids: got rdy=%b ids=%0d/%0d want rdy=1 ids=4/0",
                           bus.disp_ready, bus.disp_rob_id[0], bus.disp_rob_id[1]);
    end
    tick; set_disp(2'b00); set_cdb(2'b11, 3, 4, 2'b00);
    @(negedge clk);
    checks++;
    if (bus.commit_valid !== 2'b00 || bus.disp_ready !== 1'b0) begin
      failures++; $display("FAIL ooo_c3: got cv=%b rdy=%b want cv=00 rdy=0", bus.commit_valid, bus.disp_ready);
    end
    tick; set_cdb(2'b01, 0, 0, 2'b00);
    @(negedge clk);
    checks++;
    if (bus.commit_valid !== 2'b00) begin failures++; $display("FAIL ooo_c4: got %b want 00", bus.commit_valid); end
    tick; set_cdb(2'b01, 2, 0, 2'b00);
    @(negedge clk);
    checks++;
    if (bus.commit_valid !== 2'b00) begin failures++; $display("FAIL ooo_c5: got %b want 00", bus.commit_valid); end
    tick; set_cdb(2'b00, 0, 0, 2'b00);
    @(negedge clk);
    checks++;
    if (bus.commit_valid !== 2'b11) begin failures++; $display("FAIL ooo_first_pair: got %b want 11", bus.commit_valid); end
    tick;
    @(negedge clk);
    checks++;
    if (bus.commit_valid !== 2'b11 || bus.disp_ready !== 1'b1) begin
      failures++; $display("FAIL ooo_second_pair: got cv=%b rdy=%b want cv=11 rdy=1", bus.commit_valid, bus.disp_ready);
    end
    tick;
    @(negedge clk);
    checks++;
    if (bus.commit_valid !== 2'b00) begin failures++; $display("FAIL ooo_drained: got %b want 00", bus.commit_valid); end
    tick;
  endtask

  task automatic test_full;
    set_disp(2'b11);
    tick; set_disp(2'b11);
    tick; set_disp(2'b11); bus.commit_ready = 1'b0; set_cdb(2'b01, 1, 0, 2'b00);
    @(negedge clk);
    checks++;
    if (bus.disp_ready !== 1'b0 || bus.disp_rob_id[0] !== 3'd0) begin
      failures++; $display("FAIL full_ready: got rdy=%b tail=%0d want rdy=0 tail=0", bus.disp_ready, bus.disp_rob_id[0]);
    end
    tick; set_cdb(2'b00, 0, 0, 2'b00);
    @(negedge clk);
    checks++;
    if (bus.commit_valid !== 2'b00 || bus.disp_ready !== 1'b0) begin
      failures++; $display("FAIL hold_commit: got cv=%b rdy=%b want cv=00 rdy=0", bus.commit_valid, bus.disp_ready);
    end
    tick; bus.commit_ready = 1'b1; set_disp(2'b00);
    @(negedge clk);
    checks++;
    if (bus.commit_valid !== 2'b01 || bus.disp_ready !== 1'b0) begin
      failures++; $display("FAIL full_commit1: got cv=%b rdy=%b want cv=01 rdy=0", bus.commit_valid, bus.disp_ready);
    end
    tick; set_disp(2'b11);
    @(negedge clk);
    checks++;
    if (bus.disp_ready !== 1'b1 || bus.disp_rob_id[0] !== 3'd0 || bus.disp_rob_id[1] !== 3'd1) begin
      failures++; $display("FAIL full_reopen: got rdy=%b ids=%0d/%0d want rdy=1 ids=0/1",
                           bus.disp_ready, bus.disp_rob_id[0], bus.disp_rob_id[1]);
    end
    tick; set_disp(2'b11); set_cdb(2'b11, 2, 3, 2'b00);
    @(negedge clk);
    checks++;
    if (bus.disp_ready !== 1'b0 || bus.commit_valid !== 2'b00) begin
      failures++; $display("FAIL full_depth: got rdy=%b cv=%b want rdy=0 cv=00", bus.disp_ready, bus.commit_valid);
    end
    tick; set_disp(2'b00); set_cdb(2'b11, 4, 0, 2'b00);
    @(negedge clk);
    checks++;
    if (bus.commit_valid !== 2'b11) begin failures++; $display("FAIL full_drain1: got %b want 11", bus.commit_valid); end
    tick; set_cdb(2'b01, 1, 0, 2'b00);
    @(negedge clk);
    checks++;
    if (bus.commit_valid !== 2'b11) begin failures++; $display("FAIL full_drain2: got %b want 11", bus.commit_valid); end
    tick; set_cdb(2'b00, 0, 0, 2'b00);
    @(negedge clk);
    checks++;
    if (bus.commit_valid !== 2'b01) begin failures++; $display("FAIL full_drain3: got %b want 01", bus.commit_valid); end
    tick;
  endtask

  task automatic test_partial;
    set_disp(2'b10);
    @(negedge clk);
    checks++;
    if (bus.disp_rob_id[0] !== 3'd2 || bus.disp_rob_id[1] !== 3'd2) begin
      failures++; $display("FAIL partial_ids: got %0d/%0d want 2/2", bus.disp_rob_id[0], bus.disp_rob_id[1]);
    end
    tick; set_disp(2'b00); set_cdb(2'b01, 2, 0, 2'b00);
    @(negedge clk);
    checks++;
    if (bus.disp_rob_id[0] !== 3'd3) begin failures++; $display("FAIL partial_tail: got %0d want 3", bus.disp_rob_id[0]); end
    tick; set_cdb(2'b00, 0, 0, 2'b00);
    @(negedge clk);
    checks++;
    if (bus.commit_valid !== 2'b01) begin failures++; $display("FAIL partial_commit: got %b want 01", bus.commit_valid); end
    tick;
  endtask

  task automatic test_hold_reset;
    bus.commit_ready = 1'b0; set_disp(2'b11);
    tick; set_disp(2'b01); set_cdb(2'b11, 3, 4, 2'b00);
    tick; set_disp(2'b00); set_cdb(2'b01, 0, 0, 2'b00);
    @(negedge clk);
    checks++;
    if (bus.commit_valid !== 2'b00) begin failures++; $display("FAIL hold_ready_all: got %b want 00", bus.commit_valid); end
    tick; set_cdb(2'b00, 0, 0, 2'b00);
    @(negedge clk);
    checks++;
    if (bus.commit_valid !== 2'b00 || bus.disp_rob_id[0] !== 3'd1 || bus.disp_ready !== 1'b1) begin
      failures++; $display("FAIL hold_state: got cv=%b tail=%0d rdy=%b want cv=00 tail=1 rdy=1",
                           bus.commit_valid, bus.disp_rob_id[0], bus.disp_ready);
    end
    tick; bus.commit_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.commit_valid !== 2'b11) begin failures++; $display("FAIL hold_release: got %b want 11", bus.commit_valid); end
    #1; rst = 1'b1; set_disp(2'b11);
    #1;
    checks++;
    if (bus.commit_valid !== 2'b00 || bus.disp_rob_id[0] !== 3'd0 || bus.disp_rob_id[1] !== 3'd1 || bus.disp_ready !== 1'b1) begin
      failures++; $display("FAIL midreset: got cv=%b ids=%0d/%0d rdy=%b want cv=00 ids=0/1 rdy=1",
                           bus.commit_valid, bus.disp_rob_id[0], bus.disp_rob_id[1], bus.disp_ready);
    end
    sb.delete();
    tick; rst = 1'b0; set_disp(2'b00);
    tick;
  endtask

`ifdef ROB_FLUSH_EN
  task automatic test_flush;
    bus.commit_ready = 1'b0; set_disp(2'b11);
    tick; set_disp(2'b01); set_cdb(2'b11, 0, 1, 2'b01);
    tick; set_disp(2'b00); set_cdb(2'b01, 2, 0, 2'b00);
    tick; set_cdb(2'b00, 0, 0, 2'b00); bus.commit_ready = 1'b1; set_disp(2'b11);
    @(negedge clk);
    checks++;
    if (bus.commit_valid !== 2'b01 || bus.disp_ready !== 1'b0 || bus.flush_valid !== 1'b0) begin
      failures++; $display("FAIL flush_detect: got cv=%b rdy=%b fv=%b want cv=01 rdy=0 fv=0",
                           bus.commit_valid, bus.disp_ready, bus.flush_valid);
    end
    tick;
    @(negedge clk);
    checks++;
    if (bus.flush_valid !== 1'b1 || bus.disp_ready !== 1'b0 || bus.commit_valid !== 2'b00 || bus.disp_rob_id[0] !== 3'd1) begin
      failures++; $display("FAIL flush_pulse: got fv=%b rdy=%b cv=%b tail=%0d want fv=1 rdy=0 cv=00 tail=1",
                           bus.flush_valid, bus.disp_ready, bus.commit_valid, bus.disp_rob_id[0]);
    end
    sb.delete();
    tick;
    @(negedge clk);
    checks++;
    if (bus.flush_valid !== 1'b0 || bus.disp_ready !== 1'b1 || bus.disp_rob_id[0] !== 3'd1 || bus.commit_valid !== 2'b00) begin
      failures++; $display("FAIL flush_after: got fv=%b rdy=%b tail=%0d cv=%b want fv=0 rdy=1 tail=1 cv=00",
                           bus.flush_valid, bus.disp_ready, bus.disp_rob_id[0], bus.commit_valid);
    end
    tick; set_disp(2'b00); set_cdb(2'b11, 1, 2, 2'b00);
    @(negedge clk);
    checks++;
    if (bus.commit_valid !== 2'b00) begin failures++; $display("FAIL flush_stale_ready: got %b want 00", bus.commit_valid); end
    tick; set_cdb(2'b00, 0, 0, 2'b00);
    @(negedge clk);
    checks++;
    if (bus.commit_valid !== 2'b11) begin failures++; $display("FAIL flush_resume: got %b want 11", bus.commit_valid); end
    tick;
  endtask
`endif

  initial begin
    rst = 1'b1;
    bus.commit_ready = 1'b1;
    set_disp(2'b00);
    set_cdb(2'b00, 0, 0, 2'b00);
    #3;
    test_reset();
    test_basic();
    test_ooo();
    test_full();
    test_partial();
    test_hold_reset();
`ifdef ROB_FLUSH_EN
    test_flush();
`endif
    tick; tick;
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL sb_leftover: got %0d outstanding want 0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
